// File: rtl/cpu_control_fsm_v2.sv
// Multi-cycle fetch/decode/execute/mem/write-back sequencer for a 16-bit CR16-style datapath.
// Optional MEM wait-state timeout is enabled by defining MEM_TIMEOUT_EN.
module cpu_control_fsm_v2 #(
    parameter int INSTR_W        = 16,
    parameter int FLAG_W         = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [FLAG_W-1:0]  psr_flags,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               pc_inc_or_set,
    output logic               ir_en,
    output logic               rf_we,
    output logic               pc_reg_sel,
    output logic               r2_im_sel,
    output logic [1:0]         imm_type_sel,
    output logic               wb_reg_alu,
    output logic               psr_en,
    output logic               mem_req,
    output logic               mem_we,
    output logic               illegal,
    output logic               bus_err
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0] w_op;
    logic [3:0] w_ext;
    logic [3:0] w_cond;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_cond_true;
    logic       w_unused;

    assign w_op       = instruction[INSTR_W-1 -: 4];
    assign w_ext      = instruction[7:4];
    assign w_cond     = instruction[11:8];
    assign w_is_load  = (w_op == 4'b0100) && (w_ext == 4'b0000);
    assign w_is_store = (w_op == 4'b0100) && (w_ext == 4'b0100);

    // Flag layout: bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N.
    function automatic logic f_cond(input logic [3:0] c, input logic [FLAG_W-1:0] f);
        logic fc, fl, ff, fz, fn;
        fc = f[0];
        fl = f[1];
        ff = f[2];
        fz = f[3];
        fn = f[4];
        case (c)
            4'h0:    f_cond = fz;
            4'h1:    f_cond = !fz;
            4'h2:    f_cond = fc;
            4'h3:    f_cond = !fc;
            4'h4:    f_cond = fl;
            4'h5:    f_cond = !fl;
            4'h6:    f_cond = fn;
            4'h7:    f_cond = !fn;
            4'h8:    f_cond = ff;
            4'h9:    f_cond = !ff;
            4'hA:    f_cond = !fl && !fz;
            4'hB:    f_cond = fl || fz;
            4'hC:    f_cond = !fn && !fz;
            4'hD:    f_cond = fn || fz;
            4'hE:    f_cond = 1'b1;
            default: f_cond = 1'b0;
        endcase
    endfunction

    assign w_cond_true = f_cond(w_cond, psr_flags);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_timeout;

    // Counts MEM cycles that ended without ready; zero on every MEM entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (r_state != S_MEM) begin
            r_wait_cnt <= '0;
        end else if (!mem_ready) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !mem_ready;
    assign w_unused  = ^{instruction, psr_flags};
`else
    logic w_timeout;

    assign w_timeout = 1'b0;
    assign w_unused  = ^{instruction, psr_flags, (TIMEOUT_CYCLES < 2)};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        pc_en         = 1'b0;
        pc_inc_or_set = 1'b0;
        ir_en         = 1'b0;
        rf_we         = 1'b0;
        pc_reg_sel    = 1'b1;
        r2_im_sel     = 1'b0;
        imm_type_sel  = 2'b00;
        wb_reg_alu    = 1'b1;
        psr_en        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        illegal       = 1'b0;
        bus_err       = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_next = S_DECODE;
            end

            S_DECODE: begin
                ir_en  = 1'b1;
                w_next = S_EXECUTE;
            end

            S_EXECUTE: begin
                case (w_op)
                    4'b0000: begin
                        psr_en = 1'b1;
                        if (w_ext == 4'b1011) begin
                            pc_en  = 1'b1;
                            w_next = S_FETCH;
                        end else begin
                            w_next = S_WB;
                        end
                    end
                    4'b0001, 4'b0010, 4'b0011, 4'b1101: begin
                        r2_im_sel    = 1'b1;
                        imm_type_sel = 2'b10;
                        psr_en       = 1'b1;
                        w_next       = S_WB;
                    end
                    4'b0101, 4'b1001: begin
                        r2_im_sel    = 1'b1;
                        imm_type_sel = 2'b01;
                        psr_en       = 1'b1;
                        w_next       = S_WB;
                    end
                    4'b1011: begin
                        r2_im_sel    = 1'b1;
                        imm_type_sel = 2'b01;
                        psr_en       = 1'b1;
                        pc_en        = 1'b1;
                        w_next       = S_FETCH;
                    end
                    4'b1000, 4'b1111: begin
                        r2_im_sel    = 1'b1;
                        imm_type_sel = 2'b00;
                        psr_en       = 1'b1;
                        w_next       = S_WB;
                    end
                    4'b0100: begin
                        if (w_is_load || w_is_store) begin
                            w_next = S_MEM;
                        end else if (w_ext == 4'b1100) begin
                            pc_en         = 1'b1;
                            pc_inc_or_set = w_cond_true;
                            w_next        = S_FETCH;
                        end else begin
                            illegal = 1'b1;
                            pc_en   = 1'b1;
                            w_next  = S_FETCH;
                        end
                    end
                    4'b1100: begin
                        pc_reg_sel    = 1'b0;
                        r2_im_sel     = 1'b1;
                        imm_type_sel  = 2'b11;
                        pc_en         = 1'b1;
                        pc_inc_or_set = w_cond_true;
                        w_next        = S_FETCH;
                    end
                    default: begin
                        illegal = 1'b1;
                        pc_en   = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_store;
                if (mem_ready) begin
                    if (w_is_store) begin
                        pc_en  = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    // Abandon the access: no write-back, move on to the next instruction.
                    bus_err = 1'b1;
                    mem_req = 1'b0;
                    mem_we  = 1'b0;
                    pc_en   = 1'b1;
                    w_next  = S_FETCH;
                end
            end

            S_WB: begin
                rf_we      = 1'b1;
                pc_en      = 1'b1;
                wb_reg_alu = !w_is_load;
                w_next     = S_FETCH;
            end

            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm_v2.sv
// Directed bench for cpu_control_fsm_v2: per-instruction table plus multi-cycle MEM/reset sequences.
module tb_cpu_control_fsm_v2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instruction = 16'h0000;
    logic [4:0]  psr_flags = 5'h00;
    logic        mem_ready = 1'b0;
    logic        pc_en, pc_inc_or_set, ir_en, rf_we, pc_reg_sel, r2_im_sel;
    logic [1:0]  imm_type_sel;
    logic        wb_reg_alu, psr_en, mem_req, mem_we, illegal, bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cpu_control_fsm_v2 #(
        .INSTR_W        (16),
        .FLAG_W         (5),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .instruction   (instruction),
        .psr_flags     (psr_flags),
        .mem_ready     (mem_ready),
        .pc_en         (pc_en),
        .pc_inc_or_set (pc_inc_or_set),
        .ir_en         (ir_en),
        .rf_we         (rf_we),
        .pc_reg_sel    (pc_reg_sel),
        .r2_im_sel     (r2_im_sel),
        .imm_type_sel  (imm_type_sel),
        .wb_reg_alu    (wb_reg_alu),
        .psr_en        (psr_en),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .illegal       (illegal),
        .bus_err       (bus_err)
    );

    // {pc_en, pc_inc_or_set, ir_en, rf_we, pc_reg_sel, r2_im_sel, imm[1:0], wb_reg_alu, psr_en, mem_req, mem_we, illegal, bus_err}
    logic [13:0] w_out;
    assign w_out = {pc_en, pc_inc_or_set, ir_en, rf_we, pc_reg_sel, r2_im_sel, imm_type_sel,
                    wb_reg_alu, psr_en, mem_req, mem_we, illegal, bus_err};

    localparam logic [13:0] O_FETCH  = 14'h0220;
    localparam logic [13:0] O_DECODE = 14'h0A20;
    localparam logic [13:0] O_WB_ALU = 14'h2620;
    localparam logic [13:0] O_WB_LD  = 14'h2600;
    localparam logic [13:0] O_MEM_LD = 14'h0228;
    localparam logic [13:0] O_MEM_ST = 14'h022C;

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [4:0]  flags;
        logic [13:0] exp_e;
        logic [13:0] exp_n;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string nm, input logic [13:0] exp);
        checks++;
        if (w_out !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, w_out, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic start(input logic [15:0] ins, input logic [4:0] fl, input logic rdy);
        @(posedge clock);
        #2;
        reset       = 1'b0;
        instruction = ins;
        psr_flags   = fl;
        mem_ready   = rdy;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"ADDI",     16'h5103, 5'h00, 14'h0370, O_WB_ALU};
        vecs[1]  = '{"SUBI",     16'h9203, 5'h00, 14'h0370, O_WB_ALU};
        vecs[2]  = '{"ANDI",     16'h1105, 5'h00, 14'h03B0, O_WB_ALU};
        vecs[3]  = '{"ORI",      16'h2105, 5'h00, 14'h03B0, O_WB_ALU};
        vecs[4]  = '{"MOVI",     16'hD1FF, 5'h00, 14'h03B0, O_WB_ALU};
        vecs[5]  = '{"LSHI",     16'h8101, 5'h00, 14'h0330, O_WB_ALU};
        vecs[6]  = '{"LUI",      16'hF1AA, 5'h00, 14'h0330, O_WB_ALU};
        vecs[7]  = '{"ADD",      16'h0152, 5'h00, 14'h0230, O_WB_ALU};
        vecs[8]  = '{"CMP",      16'h01B2, 5'h00, 14'h2230, O_FETCH};
        vecs[9]  = '{"CMPI",     16'hB105, 5'h00, 14'h2370, O_FETCH};
        vecs[10] = '{"LOAD",     16'h4201, 5'h00, O_FETCH,  O_MEM_LD};
        vecs[11] = '{"STORE",    16'h4241, 5'h00, O_FETCH,  O_MEM_ST};
        vecs[12] = '{"JEQ_T",    16'h40C1, 5'h08, 14'h3220, O_FETCH};
        vecs[13] = '{"JEQ_N",    16'h40C1, 5'h00, 14'h2220, O_FETCH};
        vecs[14] = '{"JCS_T",    16'h42C3, 5'h01, 14'h3220, O_FETCH};
        vecs[15] = '{"BEQ_T",    16'hC0FE, 5'h08, 14'h31E0, O_FETCH};
        vecs[16] = '{"BEQ_N",    16'hC0FE, 5'h00, 14'h21E0, O_FETCH};
        vecs[17] = '{"BHI_T",    16'hC410, 5'h02, 14'h31E0, O_FETCH};
        vecs[18] = '{"BLO_T",    16'hCA10, 5'h00, 14'h31E0, O_FETCH};
        vecs[19] = '{"BLT_N",    16'hCC10, 5'h10, 14'h21E0, O_FETCH};
        vecs[20] = '{"BNEVER",   16'hCF10, 5'h1F, 14'h21E0, O_FETCH};
        vecs[21] = '{"ILLEGAL",  16'h7000, 5'h00, 14'h2222, O_FETCH};

        // Reset held: defaults on all outputs.
        #3;
        check("reset_hold", O_FETCH);

        for (int i = 0; i < 22; i++) begin
            start(vecs[i].instr, vecs[i].flags, 1'b0);
            check({vecs[i].name, "_fetch"}, O_FETCH);
            tick();
            check({vecs[i].name, "_decode"}, O_DECODE);
            tick();
            check({vecs[i].name, "_exec"}, vecs[i].exp_e);
            tick();
            check({vecs[i].name, "_next"}, vecs[i].exp_n);
        end

        // More illegal encodings inside and outside the 0100 group.
        start(16'h4030, 5'h00, 1'b0);
        tick(); tick();
        check("ILL_0100_exec", 14'h2222);
        start(16'hE000, 5'h00, 1'b0);
        tick(); tick();
        check("ILL_1110_exec", 14'h2222);

        // LOAD with three wait cycles, ready on the fourth MEM cycle.
        start(16'h4201, 5'h00, 1'b0);
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("LOAD_wait", O_MEM_LD);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        check("LOAD_ready", O_MEM_LD);
        tick();
        mem_ready = 1'b0;
        check("LOAD_wb", O_WB_LD);
        tick();
        check("LOAD_after", O_FETCH);

        // STORE with ready held high throughout; ready outside MEM must be ignored.
        start(16'h4241, 5'h00, 1'b1);
        check("ST_fetch_rdy", O_FETCH);
        tick();
        check("ST_decode_rdy", O_DECODE);
        tick();
        check("ST_exec_rdy", O_FETCH);
        tick();
        check("ST_mem_done", 14'h222C);
        tick();
        check("ST_after", O_FETCH);
        mem_ready = 1'b0;

        // Asynchronous reset while in MEM.
        start(16'h4201, 5'h00, 1'b0);
        tick(); tick(); tick();
        check("RST_in_mem", O_MEM_LD);
        #1;
        reset = 1'b0;
        #1;
        check("RST_async_drop", O_FETCH);
        tick();
        check("RST_held", O_FETCH);
        reset = 1'b1;
        tick();
        check("RST_restart", O_DECODE);

`ifdef MEM_TIMEOUT_EN
        // Ready never arrives: bus error on the fourth MEM cycle.
        start(16'h4201, 5'h00, 1'b0);
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("TMO_wait", O_MEM_LD);
        end
        tick();
        check("TMO_buserr", 14'h2221);
        tick();
        check("TMO_after", O_FETCH);

        // Ready on the limit cycle beats the timeout.
        start(16'h4201, 5'h00, 1'b0);
        tick(); tick(); tick(); tick(); tick(); tick();
        mem_ready = 1'b1;
        #1;
        check("TMO_ready_wins", O_MEM_LD);
        tick();
        mem_ready = 1'b0;
        check("TMO_ready_wb", O_WB_LD);
`else
        // Without the timeout, MEM waits indefinitely and bus_err stays low.
        start(16'h4201, 5'h00, 1'b0);
        tick(); tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("NOTMO_wait", O_MEM_LD);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("NOTMO_wb", O_WB_LD);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
